// File: rtl/eth_frame_rx.sv
// eth_frame_rx: strips the 14-byte Ethernet II header from 64-bit MAC RX frames and steers the realigned payload to the IP or ARP path.
// Optional destination MAC filtering is compiled in when ETH_RX_MAC_FILTER_EN is defined.
module eth_frame_rx #(
   parameter logic [15:0] ETH_TYPE_IP  = 16'h0800,
   parameter logic [15:0] ETH_TYPE_ARP = 16'h0806
) (
   input  logic        rx_axis_aclk,
   input  logic        rx_axis_areset,
   input  logic [47:0] local_mac_addr,
   input  logic [63:0] mac_rx_axis_tdata,
   input  logic [7:0]  mac_rx_axis_tkeep,
   input  logic        mac_rx_axis_tvalid,
   input  logic        mac_rx_axis_tlast,
   input  logic        mac_rx_axis_tuser,
   output logic        mac_rx_axis_tready,
   output logic [63:0] pay_rx_axis_tdata,
   output logic [7:0]  pay_rx_axis_tkeep,
   output logic        pay_rx_axis_tlast,
   output logic        pay_rx_axis_tuser,
   output logic        ip_rx_axis_tvalid,
   input  logic        ip_rx_axis_tready,
   output logic        arp_rx_axis_tvalid,
   input  logic        arp_rx_axis_tready,
   output logic [47:0] rx_src_mac_addr,
   output logic [15:0] rx_eth_type,
   output logic        rx_drop
);

   typedef enum logic [2:0] {S_HDR0, S_HDR1, S_PAY, S_FLUSH, S_DROP} state_t;

   state_t      state, state_nxt;
   logic        out_valid;
   logic [15:0] hold;
   logic [1:0]  hold_keep;
   logic        hold_user;
   logic [15:0] src_hi;

   logic        is_ip, is_arp, sel_tready, out_free, accept;
   logic [15:0] beat_type;
   logic        type_known, dst_ok;

   logic        load, ld_last, ld_user, drop_nxt;
   logic [63:0] ld_data;
   logic [7:0]  ld_keep;

   // Steering follows the EtherType of the frame currently in the output register.
   assign is_ip              = (rx_eth_type == ETH_TYPE_IP);
   assign is_arp             = (rx_eth_type == ETH_TYPE_ARP);
   assign sel_tready         = (is_ip & ip_rx_axis_tready) | (is_arp & arp_rx_axis_tready);
   assign ip_rx_axis_tvalid  = out_valid & is_ip;
   assign arp_rx_axis_tvalid = out_valid & is_arp;
   assign out_free           = !out_valid || sel_tready;
   assign accept             = mac_rx_axis_tvalid && mac_rx_axis_tready;

   assign beat_type  = {mac_rx_axis_tdata[39:32], mac_rx_axis_tdata[47:40]};
   assign type_known = (beat_type == ETH_TYPE_IP) || (beat_type == ETH_TYPE_ARP);

`ifdef ETH_RX_MAC_FILTER_EN
   logic [47:0] dst_mac;

   assign dst_ok = (dst_mac == local_mac_addr) || (dst_mac == 48'hFFFF_FFFF_FFFF);

   always_ff @(posedge rx_axis_aclk) begin
      if (rx_axis_areset)
         dst_mac <= '0;
      else if (accept && state == S_HDR0)
         dst_mac <= {mac_rx_axis_tdata[7:0],   mac_rx_axis_tdata[15:8],
                     mac_rx_axis_tdata[23:16], mac_rx_axis_tdata[31:24],
                     mac_rx_axis_tdata[39:32], mac_rx_axis_tdata[47:40]};
   end
`else
   logic unused_mac;

   assign unused_mac = ^local_mac_addr;
   assign dst_ok     = 1'b1;
`endif

   always_comb begin
      case (state)
         S_FLUSH: mac_rx_axis_tready = 1'b0;
         S_DROP:  mac_rx_axis_tready = 1'b1;
         default: mac_rx_axis_tready = out_free;
      endcase
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      state_nxt = state;
      load      = 1'b0;
      ld_data   = {mac_rx_axis_tdata[47:0], hold};
      ld_keep   = {mac_rx_axis_tkeep[5:0], 2'b11};
      ld_last   = 1'b0;
      ld_user   = 1'b0;
      drop_nxt  = 1'b0;
      case (state)
         S_HDR0: begin
            if (accept) begin
               if (mac_rx_axis_tlast) drop_nxt  = 1'b1;
               else                   state_nxt = S_HDR1;
            end
         end
         S_HDR1: begin
            if (accept) begin
               if (!type_known || !dst_ok) begin
                  if (mac_rx_axis_tlast) begin
                     drop_nxt  = 1'b1;
                     state_nxt = S_HDR0;
                  end else begin
                     state_nxt = S_DROP;
                  end
               end else if (mac_rx_axis_tlast) begin
                  // One or two payload bytes sit in the hold register; none means an empty frame.
                  if (mac_rx_axis_tkeep[6]) begin
                     state_nxt = S_FLUSH;
                  end else begin
                     drop_nxt  = 1'b1;
                     state_nxt = S_HDR0;
                  end
               end else begin
                  state_nxt = S_PAY;
               end
            end
         end
         S_PAY: begin
            if (accept) begin
               load    = 1'b1;
               ld_last = mac_rx_axis_tlast && !mac_rx_axis_tkeep[6];
               ld_user = ld_last && mac_rx_axis_tuser;
               if (mac_rx_axis_tlast)
                  state_nxt = mac_rx_axis_tkeep[6] ? S_FLUSH : S_HDR0;
            end
         end
         S_FLUSH: begin
            if (out_free) begin
               load      = 1'b1;
               ld_data   = {48'h0, hold};
               ld_keep   = {6'b0, hold_keep};
               ld_last   = 1'b1;
               ld_user   = hold_user;
               state_nxt = S_HDR0;
            end
         end
         S_DROP: begin
            if (accept && mac_rx_axis_tlast) begin
               drop_nxt  = 1'b1;
               state_nxt = S_HDR0;
            end
         end
         default: state_nxt = S_HDR0;
      endcase
   end

   always_ff @(posedge rx_axis_aclk) begin
      // NOTE: the hold register is reset too, so a frame cut by reset leaves no stale bytes behind.
      if (rx_axis_areset) begin
         state             <= S_HDR0;
         out_valid         <= 1'b0;
         pay_rx_axis_tdata <= '0;
         pay_rx_axis_tkeep <= '0;
         pay_rx_axis_tlast <= 1'b0;
         pay_rx_axis_tuser <= 1'b0;
         hold              <= '0;
         hold_keep         <= '0;
         hold_user         <= 1'b0;
         src_hi            <= '0;
         rx_src_mac_addr   <= '0;
         rx_eth_type       <= '0;
         rx_drop           <= 1'b0;
      end else begin
         state   <= state_nxt;
         rx_drop <= drop_nxt;

         if (load) begin
            out_valid         <= 1'b1;
            pay_rx_axis_tdata <= ld_data;
            pay_rx_axis_tkeep <= ld_keep;
            pay_rx_axis_tlast <= ld_last;
            pay_rx_axis_tuser <= ld_user;
         end else if (sel_tready) begin
            out_valid <= 1'b0;
         end

         if (accept && state == S_HDR0)
            src_hi <= mac_rx_axis_tdata[63:48];

         if (accept && state == S_HDR1) begin
            rx_src_mac_addr <= {src_hi[7:0], src_hi[15:8],
                                mac_rx_axis_tdata[7:0],   mac_rx_axis_tdata[15:8],
                                mac_rx_axis_tdata[23:16], mac_rx_axis_tdata[31:24]};
            rx_eth_type     <= beat_type;
         end

         // The top two bytes of every payload-bearing beat wait here for the next output beat.
         if (accept && (state == S_HDR1 || state == S_PAY)) begin
            hold      <= mac_rx_axis_tdata[63:48];
            hold_keep <= mac_rx_axis_tkeep[7:6];
            hold_user <= mac_rx_axis_tuser;
         end
      end
   end

endmodule

// File: tb/tb_eth_frame_rx.sv
// Self-checking bench for eth_frame_rx: directed vector table, reset-mid-frame sequence and randomized frames
// checked beat-by-beat against a byte-level payload model.
`timescale 1ns/1ps
module tb_eth_frame_rx;

   localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_AA;
   localparam logic [47:0] BCAST_MAC = 48'hFF_FF_FF_FF_FF_FF;
   localparam logic [47:0] OTHER_MAC = 48'h02_00_00_00_00_01;
`ifdef ETH_RX_MAC_FILTER_EN
   localparam bit FILTER_ON = 1'b1;
`else
   localparam bit FILTER_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        areset = 1'b1;
   logic [63:0] in_data = '0;
   logic [7:0]  in_keep = '0;
   logic        in_valid = 1'b0, in_last = 1'b0, in_user = 1'b0;
   logic        mac_tready;
   logic [63:0] pay_data;
   logic [7:0]  pay_keep;
   logic        pay_last, pay_user;
   logic        ip_tvalid, arp_tvalid;
   logic        ip_tready = 1'b1, arp_tready = 1'b1;
   logic [47:0] src_mac;
   logic [15:0] eth_type;
   logic        drop;

   always #5 clk = ~clk;

   eth_frame_rx dut (
      .rx_axis_aclk       (clk),
      .rx_axis_areset     (areset),
      .local_mac_addr     (LOCAL_MAC),
      .mac_rx_axis_tdata  (in_data),
      .mac_rx_axis_tkeep  (in_keep),
      .mac_rx_axis_tvalid (in_valid),
      .mac_rx_axis_tlast  (in_last),
      .mac_rx_axis_tuser  (in_user),
      .mac_rx_axis_tready (mac_tready),
      .pay_rx_axis_tdata  (pay_data),
      .pay_rx_axis_tkeep  (pay_keep),
      .pay_rx_axis_tlast  (pay_last),
      .pay_rx_axis_tuser  (pay_user),
      .ip_rx_axis_tvalid  (ip_tvalid),
      .ip_rx_axis_tready  (ip_tready),
      .arp_rx_axis_tvalid (arp_tvalid),
      .arp_rx_axis_tready (arp_tready),
      .rx_src_mac_addr    (src_mac),
      .rx_eth_type        (eth_type),
      .rx_drop            (drop)
   );

   typedef struct {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic        user;
      logic        arp;
   } beat_t;

   typedef struct {
      int          total;
      logic [15:0] etype;
      bit          bcast;
      bit          err;
      int          exp_beats;
      logic [7:0]  exp_last_keep;
      int          exp_drops;
      int          exp_stall;
   } vec_t;

   beat_t       exp_q[$];
   logic [7:0]  fbytes[$];
   int          checks = 0, failures = 0;
   int          beats_seen = 0, drops_seen = 0, exp_drops = 0, stall_cnt = 0;
   int          sink_mode = 0;
   logic [7:0]  last_keep_seen = '0;
   bit          stalled = 1'b0;
   logic [63:0] held_data = '0;
   logic [9:0]  held_ctl = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Sink: 0 always ready, 1 toggle each cycle, 2 random, 3 never ready.
   always @(posedge clk) begin
      #1;
      case (sink_mode)
         0:       ip_tready = 1'b1;
         1:       ip_tready = !ip_tready;
         2:       ip_tready = 1'($urandom_range(0, 1));
         default: ip_tready = 1'b0;
      endcase
      arp_tready = ip_tready;
   end

   task automatic take_beat();
      beat_t       e;
      logic [63:0] mask;
      beats_seen++;
      last_keep_seen = pay_keep;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_beat actual=%h/%h required=no beat t=%0t", pay_data, pay_keep, $time);
      end else begin
         e = exp_q.pop_front();
         for (int i = 0; i < 8; i++) mask[i*8 +: 8] = {8{e.keep[i]}};
         check("pay_keep", 64'(pay_keep), 64'(e.keep));
         check("pay_data", pay_data & mask, e.data & mask);
         check("pay_last", 64'(pay_last), 64'(e.last));
         check("pay_user", 64'(pay_user), 64'(e.user));
         check("pay_path_arp", 64'(arp_tvalid), 64'(e.arp));
      end
   endtask

   always @(negedge clk) begin
      if (areset) begin
         stalled = 1'b0;
      end else begin
         if (ip_tvalid || arp_tvalid) begin
            check("one_path", 64'(ip_tvalid & arp_tvalid), 64'(0));
            if (stalled) begin
               check("stall_data", pay_data, held_data);
               check("stall_ctl", 64'({pay_keep, pay_last, pay_user}), 64'(held_ctl));
            end
            if ((ip_tvalid && ip_tready) || (arp_tvalid && arp_tready)) begin
               take_beat();
               stalled = 1'b0;
            end else begin
               stalled   = 1'b1;
               held_data = pay_data;
               held_ctl  = {pay_keep, pay_last, pay_user};
            end
         end else begin
            stalled = 1'b0;
         end
         if (drop) drops_seen++;
         if (!mac_tready) stall_cnt++;
      end
   end

   task automatic build_frame(input int total, input logic [47:0] dst, input logic [47:0] src,
                              input logic [15:0] et, input bit ramp);
      logic [111:0] hdr;
      hdr = {dst, src, et};
      fbytes.delete();
      for (int i = 0; i < total; i++) begin
         if (i < 14) fbytes.push_back(hdr[111 - 8*i -: 8]);
         else        fbytes.push_back(ramp ? 8'(i - 13) : 8'($urandom));
      end
   endtask

   // Reference: payload = bytes 14.. of the frame, cut into 8-byte beats, routed by EtherType.
   task automatic model_frame(input bit err);
      logic [15:0] et;
      logic [47:0] dst;
      bit          known, dst_ok;
      int          n;
      beat_t       b;
      if (fbytes.size() < 15) begin
         exp_drops++;
         return;
      end
      et     = {fbytes[12], fbytes[13]};
      dst    = {fbytes[0], fbytes[1], fbytes[2], fbytes[3], fbytes[4], fbytes[5]};
      known  = (et == 16'h0800) || (et == 16'h0806);
      dst_ok = !FILTER_ON || dst == LOCAL_MAC || dst == BCAST_MAC;
      if (!known || !dst_ok) begin
         exp_drops++;
         return;
      end
      n = fbytes.size() - 14;
      for (int off = 0; off < n; off += 8) begin
         b.data = '0;
         b.keep = '0;
         for (int i = 0; i < 8 && off + i < n; i++) begin
            b.data[i*8 +: 8] = fbytes[14 + off + i];
            b.keep[i]        = 1'b1;
         end
         b.last = (off + 8 >= n);
         b.user = b.last & err;
         b.arp  = (et == 16'h0806);
         exp_q.push_back(b);
      end
   endtask

   task automatic send_frame(input int max_beats, input bit gaps, input bit err);
      int nb, t;
      bit acc;
      nb = (fbytes.size() + 7) / 8;
      for (int b = 0; b < nb && b < max_beats; b++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         in_data = '0;
         in_keep = '0;
         for (int i = 0; i < 8; i++) begin
            if (b*8 + i < fbytes.size()) begin
               in_data[i*8 +: 8] = fbytes[b*8 + i];
               in_keep[i]        = 1'b1;
            end
         end
         in_last  = (b == nb - 1);
         in_user  = in_last ? err : 1'($urandom_range(0, 1));
         in_valid = 1'b1;
         t   = 0;
         acc = 1'b0;
         while (!acc && t < 1000) begin
            @(negedge clk);
            acc = mac_tready;
            @(posedge clk);
            #1;
            t++;
         end
         check("input_accept", 64'(acc), 64'(1));
         if (!acc) break;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_user  = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 3000) begin
         @(posedge clk);
         t++;
      end
      check("drain_queue", 64'(exp_q.size()), 64'(0));
      repeat (4) @(posedge clk);
      #1;
   endtask

   vec_t vecs[10];

   initial begin
      logic [47:0] src;
      int          b0, d0;

      vecs[0] = '{78, 16'h0800, 1'b0, 1'b0, 8, 8'hFF, 0, 0};
      vecs[1] = '{42, 16'h0806, 1'b1, 1'b0, 4, 8'h0F, 0, 0};
      vecs[2] = '{54, 16'h86DD, 1'b0, 1'b0, 0, 8'h00, 1, 0};
      vecs[3] = '{64, 16'h0800, 1'b0, 1'b0, 7, 8'h03, 0, 1};
      vecs[4] = '{15, 16'h0800, 1'b0, 1'b1, 1, 8'h01, 0, 1};
      vecs[5] = '{16, 16'h0806, 1'b1, 1'b0, 1, 8'h03, 0, 1};
      vecs[6] = '{14, 16'h0800, 1'b0, 1'b0, 0, 8'h00, 1, 0};
      vecs[7] = '{8,  16'h0800, 1'b0, 1'b0, 0, 8'h00, 1, 0};
      vecs[8] = '{20, 16'h0800, 1'b0, 1'b1, 1, 8'h3F, 0, 0};
      vecs[9] = '{23, 16'h0800, 1'b0, 1'b0, 2, 8'h01, 0, 1};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tready", 64'(mac_tready), 64'(1));
      check("rst_valid", 64'({ip_tvalid, arp_tvalid}), 64'(0));
      check("rst_pay", 64'({pay_keep, pay_last, pay_user}), 64'(0));
      check("rst_data", pay_data, 64'(0));
      check("rst_hdr", 64'({src_mac, eth_type}), 64'(0));
      check("rst_drop", 64'(drop), 64'(0));
      @(posedge clk);
      #1;
      areset = 1'b0;

      for (int v = 0; v < 10; v++) begin
         src = {16'($urandom), 32'($urandom)};
         build_frame(vecs[v].total, vecs[v].bcast ? BCAST_MAC : LOCAL_MAC, src, vecs[v].etype, 1'b1);
         model_frame(vecs[v].err);
         b0 = beats_seen;
         d0 = drops_seen;
         stall_cnt = 0;
         send_frame(1000, 1'b0, vecs[v].err);
         drain();
         check($sformatf("v%0d_beats", v), 64'(beats_seen - b0), 64'(vecs[v].exp_beats));
         if (vecs[v].exp_beats > 0)
            check($sformatf("v%0d_last_keep", v), 64'(last_keep_seen), 64'(vecs[v].exp_last_keep));
         check($sformatf("v%0d_drops", v), 64'(drops_seen - d0), 64'(vecs[v].exp_drops));
         check($sformatf("v%0d_tready_low", v), 64'(stall_cnt), 64'(vecs[v].exp_stall));
         if (vecs[v].total >= 14) begin
            check($sformatf("v%0d_src_mac", v), 64'(src_mac), 64'(src));
            check($sformatf("v%0d_eth_type", v), 64'(eth_type), 64'(vecs[v].etype));
         end
      end

`ifdef ETH_RX_MAC_FILTER_EN
      build_frame(40, OTHER_MAC, 48'h02_11_22_33_44_55, 16'h0800, 1'b0);
      model_frame(1'b0);
      b0 = beats_seen;
      d0 = drops_seen;
      send_frame(1000, 1'b0, 1'b0);
      drain();
      check("filter_beats", 64'(beats_seen - b0), 64'(0));
      check("filter_drops", 64'(drops_seen - d0), 64'(1));
`endif

      // Reset in the middle of a frame that is stuck in the output register.
      sink_mode = 3;
      build_frame(60, LOCAL_MAC, 48'h02_AB_CD_EF_01_23, 16'h0800, 1'b0);
      send_frame(3, 1'b0, 1'b0);
      @(negedge clk);
      check("midrst_pending", 64'(ip_tvalid), 64'(1));
      @(posedge clk);
      #1;
      areset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst_tready", 64'(mac_tready), 64'(1));
      check("midrst_valid", 64'({ip_tvalid, arp_tvalid}), 64'(0));
      check("midrst_pay", 64'({pay_keep, pay_last, pay_user}), 64'(0));
      check("midrst_data", pay_data, 64'(0));
      check("midrst_hdr", 64'({src_mac, eth_type}), 64'(0));
      @(posedge clk);
      #1;
      areset    = 1'b0;
      sink_mode = 0;
      src = 48'h02_55_66_77_88_99;
      build_frame(70, LOCAL_MAC, src, 16'h0800, 1'b0);
      model_frame(1'b0);
      b0 = beats_seen;
      send_frame(1000, 1'b0, 1'b0);
      drain();
      check("postrst_beats", 64'(beats_seen - b0), 64'(7));
      check("postrst_src_mac", 64'(src_mac), 64'(src));

      // Randomized frames under toggling and random back-pressure.
      for (int f = 0; f < 40; f++) begin
         int          total, pick;
         logic [15:0] et;
         logic [47:0] dst;
         bit          err;
         sink_mode = (f < 10) ? 1 : 2;
         total = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 14)) : int'($urandom_range(15, 150));
         pick  = $urandom_range(0, 5);
         et    = (pick <= 1) ? 16'h0800 : (pick <= 3) ? 16'h0806 : (pick == 4) ? 16'h86DD : 16'($urandom);
         dst   = ($urandom_range(0, 7) == 0) ? OTHER_MAC : ($urandom_range(0, 1) == 1) ? LOCAL_MAC : BCAST_MAC;
         err   = 1'($urandom_range(0, 1));
         src   = {16'($urandom), 32'($urandom)};
         build_frame(total, dst, src, et, 1'b0);
         model_frame(err);
         send_frame(1000, 1'b1, err);
         drain();
         if (total >= 14) begin
            check("rnd_src_mac", 64'(src_mac), 64'(src));
            check("rnd_eth_type", 64'(eth_type), 64'(et));
         end
      end

      check("total_drops", 64'(drops_seen), 64'(exp_drops));
      check("queue_empty", 64'(exp_q.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
